// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

   localparam int          FETCH_XLEN     = 32;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [31:0]           instr;
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] pc_plus4;
   } if_id_t;

   // Bubble loaded on reset and on flush.
   localparam if_id_t IF_ID_NOP = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {instr, pc, pc_plus4}.
// Latency: 1 cycle from i_d to o_q.
// Backpressure: i_stall holds contents; i_flush loads a NOP bubble and wins over i_stall.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (loads the NOP bubble)
//   i_stall  hold current contents
//   i_flush  load the NOP bubble
//   i_d      next contents from fetch
//   o_q      registered contents to decode
module if_id_reg
   import fetch_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_stall,
   input  logic   i_flush,
   input  if_id_t i_d,
   output if_id_t o_q
);

   if_id_t r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= IF_ID_NOP;
      end else if (i_flush) begin
         // Flush outranks stall so a squashed wrong-path instruction never survives.
         r_q <= IF_ID_NOP;
      end else if (!i_stall) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_pipe.sv
// RV32I fetch stage: PC register, PC+4 adder, next-PC mux and IF/ID register.
// Latency: PCF->PCPlus4F combinational; InstrF/PCF/PCPlus4F reach the D outputs 1 cycle later.
// Backpressure: StallF holds the PC (redirect still wins); StallD holds IF/ID, FlushD bubbles it.
//
// Ports:
//   clk, reset          clock and asynchronous reset (reset is active-low)
//   StallF, StallD      hold PC / hold IF/ID register
//   FlushD              load a NOP bubble into IF/ID
//   PCSrcE, PCTargetE   execute-stage redirect request and target (used unaligned as given)
//   InstrF              instruction from imem at PCF, same cycle
//   PCF, PCPlus4F       current fetch address and its successor
//   InstrD, PCD, PCPlus4D  IF/ID register outputs
//
// Build option: define FETCH_TRACE_EN for a simulation-only per-cycle fetch trace.
module fetch_pipe
   import fetch_pkg::*;
#(
   parameter int              XLEN     = FETCH_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic [31:0]     InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;
   if_id_t          w_if_d;
   if_id_t          w_if_q;

   // Wraps modulo 2^XLEN by construction of the adder width.
   assign w_pc_plus4 = r_pc + XLEN'(4);
   assign w_pc_next  = PCSrcE ? PCTargetE : w_pc_plus4;

   // A redirect must land even while fetch is stalled, otherwise the
   // control-flow change issued from execute would be lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (PCSrcE || !StallF) begin
         r_pc <= w_pc_next;
      end
   end

   assign w_if_d.instr    = InstrF;
   assign w_if_d.pc       = r_pc;
   assign w_if_d.pc_plus4 = w_pc_plus4;

   if_id_reg u_if_id_reg (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_stall (StallD),
      .i_flush (FlushD),
      .i_d     (w_if_d),
      .o_q     (w_if_q)
   );

   assign PCF      = r_pc;
   assign PCPlus4F = w_pc_plus4;
   assign InstrD   = w_if_q.instr;
   assign PCD      = w_if_q.pc;
   assign PCPlus4D = w_if_q.pc_plus4;

`ifdef FETCH_TRACE_EN
   initial $display("Time PCF PCD InstrF InstrD");
   always @(posedge clk) begin
      $display("%0t %0d %0d %h %h", $time, PCF, PCD, InstrF, InstrD);
   end
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe with a combinational imem model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fetch_pipe;

   logic        clk;
   logic        reset;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrF;
   logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;

   int n_chk = 0;
   int n_err = 0;

   fetch_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .InstrF    (InstrF),
      .PCF       (PCF),
      .PCPlus4F  (PCPlus4F),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem: word 0 holds addi x1,x0,5; every other address returns C0DE_<addr[15:0]>.
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {16'hC0DE, a[15:0]};
   endfunction

   always_comb InstrF = imem(PCF);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      PCSrcE = 1'b0; PCTargetE = 32'h0;

      // Reset held across an edge
      step();
      check("rst_pcf",      PCF,      32'h0);
      check("rst_instrd",   InstrD,   32'h0000_0013);
      check("rst_pcd",      PCD,      32'h0);
      check("rst_pcplus4d", PCPlus4D, 32'h0);
      check("rst_pcplus4f", PCPlus4F, 32'h4);

      // Release; first edge loads IF/ID from RESET_PC
      reset = 1'b1;
      step();
      check("rel_instrd",   InstrD,   32'h0050_0093);
      check("rel_pcd",      PCD,      32'h0);
      check("rel_pcplus4d", PCPlus4D, 32'h4);
      check("rel_pcf",      PCF,      32'h4);

      // Sequential fetch 8, 12, 16
      step();
      check("seq8_pcf",     PCF,      32'h8);
      check("seq8_pcd",     PCD,      32'h4);
      check("seq8_instrd",  InstrD,   32'hC0DE_0004);
      check("seq8_plus4f",  PCPlus4F, 32'hC);
      step();
      check("seq12_pcf",    PCF,      32'hC);
      check("seq12_pcd",    PCD,      32'h8);
      step();
      check("seq16_pcf",    PCF,      32'h10);
      check("seq16_pcd",    PCD,      32'hC);
      check("seq16_plus4f", PCPlus4F, 32'h14);

      // Async reset between edges, then release away from the edge
      reset = 1'b0;
      #1;
      check("arst1_pcf",    PCF,      32'h0);
      check("arst1_instrd", InstrD,   32'h0000_0013);
      check("arst1_pcd",    PCD,      32'h0);
      reset = 1'b1;
      step();
      check("rerel_pcf",    PCF,      32'h4);
      step();
      check("rerel8_pcf",   PCF,      32'h8);

      // Redirect with flush at PCF=8
      PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1;
      step();
      check("redir_pcf",    PCF,      32'h40);
      check("redir_instrd", InstrD,   32'h0000_0013);
      check("redir_pcd",    PCD,      32'h0);
      PCSrcE = 1'b0; FlushD = 1'b0;
      step();
      check("redir2_pcd",   PCD,      32'h40);
      check("redir2_instrd",InstrD,   32'hC0DE_0040);
      check("redir2_pcf",   PCF,      32'h44);

      // Move to PCF=12 without flushing, then stall two cycles
      PCSrcE = 1'b1; PCTargetE = 32'hC;
      step();
      check("to12_pcf",     PCF,      32'hC);
      check("to12_pcd",     PCD,      32'h44);
      PCSrcE = 1'b0; StallF = 1'b1; StallD = 1'b1;
      step();
      check("stall1_pcf",   PCF,      32'hC);
      check("stall1_pcd",   PCD,      32'h44);
      check("stall1_instrd",InstrD,   32'hC0DE_0044);
      step();
      check("stall2_pcf",   PCF,      32'hC);
      check("stall2_pcd",   PCD,      32'h44);
      StallF = 1'b0; StallD = 1'b0;
      step();
      check("unstall_pcf",  PCF,      32'h10);
      check("unstall_pcd",  PCD,      32'hC);

      // Flush beats stall on IF/ID
      FlushD = 1'b1; StallD = 1'b1;
      step();
      check("fls_instrd",   InstrD,   32'h0000_0013);
      check("fls_pcd",      PCD,      32'h0);
      check("fls_plus4d",   PCPlus4D, 32'h0);
      check("fls_pcf",      PCF,      32'h14);

      // Redirect beats StallF
      FlushD = 1'b0; StallD = 1'b0; StallF = 1'b1;
      PCSrcE = 1'b1; PCTargetE = 32'h80;
      step();
      check("stredir_pcf",  PCF,      32'h80);
      check("stredir_pcd",  PCD,      32'h14);
      check("stredir_instrd", InstrD, 32'hC0DE_0014);

      // StallF alone holds the PC while IF/ID keeps loading
      PCSrcE = 1'b0;
      step();
      check("stf_pcf",      PCF,      32'h80);
      check("stf_pcd",      PCD,      32'h80);

      // Wrap at the top of the address space
      StallF = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      step();
      check("wrap_pcf",     PCF,      32'hFFFF_FFFC);
      check("wrap_plus4f",  PCPlus4F, 32'h0);
      PCSrcE = 1'b0;
      step();
      check("wrap2_pcf",    PCF,      32'h0);
      check("wrap2_pcd",    PCD,      32'hFFFF_FFFC);
      check("wrap2_plus4d", PCPlus4D, 32'h0);
      check("wrap2_instrd", InstrD,   32'hC0DE_FFFC);

      // Unaligned redirect target used as given
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
      step();
      check("unal_pcf",     PCF,      32'h102);
      check("unal_plus4f",  PCPlus4F, 32'h106);
      PCSrcE = 1'b0;
      step();
      check("unal2_pcf",    PCF,      32'h106);

      // Async reset mid-operation clears everything before the next edge
      reset = 1'b0;
      #1;
      check("arst2_pcf",    PCF,      32'h0);
      check("arst2_instrd", InstrD,   32'h0000_0013);
      check("arst2_pcd",    PCD,      32'h0);
      check("arst2_plus4d", PCPlus4D, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
